// File: rtl/ysyx_23060191_exec_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/[MEM]/WB with retire counting and halt.
// Optional wait-cycle watchdog on FETCH/MEM enabled by YSYX_23060191_EXEC_CTRL_TIMEOUT_EN.
module ysyx_23060191_exec_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LSU_OPT_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ifu_rvalid,
  input  logic                     wr_en_Rd,
  input  logic                     jal_jump_en,
  input  logic                     jalr_jump_en,
  input  logic [LSU_OPT_WIDTH-1:0] lsu_opt_code,
  input  logic                     lsu_done,
  input  logic                     ebreak,
  output logic                     ifu_req,
  output logic                     inst_latch_en,
  output logic                     lsu_req,
  output logic                     gpr_wr_en,
  output logic                     pc_wr_en,
  output logic                     pc_jump_sel,
  output logic                     retire_pulse,
  output logic [63:0]              retire_cnt,
  output logic                     halted,
  output logic                     timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] retire_cnt_q;
  logic        timeout_hit;
  logic        in_wb;

`ifdef YSYX_23060191_EXEC_CTRL_TIMEOUT_EN
  // Counter equal to LIMIT-1 while still waiting means this is the LIMIT-th idle cycle.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_err_q;

  always_comb begin
    wait_cnt_d  = 16'd0;
    timeout_hit = 1'b0;
    if ((state_q == S_FETCH && !ifu_rvalid) || (state_q == S_MEM && !lsu_done)) begin
      timeout_hit = (wait_cnt_q == WAIT_LAST);
      wait_cnt_d  = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q    <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (ifu_rvalid)       state_d = S_DECODE;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_DECODE: state_d = ebreak ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (lsu_opt_code != '0) ? S_MEM : S_WB;
      S_MEM: begin
        if (lsu_done)         state_d = S_WB;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      retire_cnt_q <= 64'd0;
    end else begin
      state_q <= state_d;
      if (in_wb) retire_cnt_q <= retire_cnt_q + 64'd1;
    end
  end

  // All architectural strobes derive from the single WB cycle, so they cannot repeat.
  assign in_wb         = (state_q == S_WB);
  assign ifu_req       = (state_q == S_FETCH);
  assign inst_latch_en = (state_q == S_FETCH) && ifu_rvalid;
  assign lsu_req       = (state_q == S_MEM);
  assign gpr_wr_en     = in_wb && wr_en_Rd;
  assign pc_wr_en      = in_wb;
  assign pc_jump_sel   = in_wb && (jal_jump_en || jalr_jump_en);
  assign retire_pulse  = in_wb;
  assign retire_cnt    = retire_cnt_q;
  assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_ysyx_23060191_exec_ctrl.sv
// Directed bench for ysyx_23060191_exec_ctrl: ALU stream, delayed store, stalled jalr, ebreak, timeout.
module tb_ysyx_23060191_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_rvalid, wr_en_Rd, jal_jump_en, jalr_jump_en, lsu_done, ebreak;
  logic [3:0]  lsu_opt_code;
  logic        ifu_req, inst_latch_en, lsu_req, gpr_wr_en, pc_wr_en, pc_jump_sel;
  logic        retire_pulse, halted, timeout_err;
  logic [63:0] retire_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_23060191_exec_ctrl #(.TIMEOUT_CYCLES(8), .LSU_OPT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .ifu_rvalid(ifu_rvalid), .wr_en_Rd(wr_en_Rd),
    .jal_jump_en(jal_jump_en), .jalr_jump_en(jalr_jump_en), .lsu_opt_code(lsu_opt_code),
    .lsu_done(lsu_done), .ebreak(ebreak), .ifu_req(ifu_req), .inst_latch_en(inst_latch_en),
    .lsu_req(lsu_req), .gpr_wr_en(gpr_wr_en), .pc_wr_en(pc_wr_en), .pc_jump_sel(pc_jump_sel),
    .retire_pulse(retire_pulse), .retire_cnt(retire_cnt), .halted(halted),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then changed and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int gpr_hi;
    int lsu_hi;
    int req_hi;
    rst = 1'b1; ifu_rvalid = 1'b1; wr_en_Rd = 1'b0; jal_jump_en = 1'b0;
    jalr_jump_en = 1'b0; lsu_opt_code = 4'd0; lsu_done = 1'b0; ebreak = 1'b0;
    step();
    step();
    #1;
    // ifu_rvalid is high during reset: reset must still hold IDLE
    chk("rst_ifu_req", ifu_req, 0);
    chk("rst_latch", inst_latch_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retire_cnt", retire_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_pc_wr_en", pc_wr_en, 0);

    // ALU stream: three addi, rvalid every FETCH
    rst = 1'b0; wr_en_Rd = 1'b1;
    gpr_hi = 0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) step();
      #1;
      chk("alu_ifu_req", ifu_req, (c % 4 == 1) ? 1 : 0);
      chk("alu_latch", inst_latch_en, (c % 4 == 1) ? 1 : 0);
      chk("alu_retire", retire_pulse, (c > 0 && c % 4 == 0) ? 1 : 0);
      chk("alu_pc_wr_en", pc_wr_en, (c > 0 && c % 4 == 0) ? 1 : 0);
      chk("alu_retire_cnt", retire_cnt, (c > 0) ? 64'((c - 1) / 4) : 64'd0);
      if (gpr_wr_en) gpr_hi++;
    end
    step(); #1;
    chk("alu_gpr_cycles", 64'(gpr_hi), 3);
    chk("alu_retire_cnt_end", retire_cnt, 3);
    $display("txn alu: 3 addi retired, retire_cnt=%0d", retire_cnt);

    // Store: now in FETCH; lsu_done three cycles after lsu_req rises
    wr_en_Rd = 1'b0; lsu_opt_code = 4'h2;
    lsu_hi = 0;
    for (int j = 0; j <= 8; j++) begin
      if (j > 0) step();
      lsu_done = (j == 6);
      #1;
      chk("st_lsu_req", lsu_req, (j >= 3 && j <= 6) ? 1 : 0);
      chk("st_gpr_wr_en", gpr_wr_en, 0);
      chk("st_pc_wr_en", pc_wr_en, (j == 7) ? 1 : 0);
      chk("st_ifu_req", ifu_req, (j == 0 || j == 8) ? 1 : 0);
      if (lsu_req) lsu_hi++;
    end
    chk("st_lsu_cycles", 64'(lsu_hi), 4);
    chk("st_retire_cnt", retire_cnt, 4);
    $display("txn sw: lsu_req held %0d cycles, retire_cnt=%0d", lsu_hi, retire_cnt);

    // jalr with IFU stall: now in FETCH, rvalid arrives on the 6th FETCH cycle
    lsu_opt_code = 4'd0; lsu_done = 1'b0; wr_en_Rd = 1'b1; jalr_jump_en = 1'b1;
    req_hi = 0;
    for (int j = 0; j <= 9; j++) begin
      if (j > 0) step();
      ifu_rvalid = (j == 5);
      #1;
      chk("jr_ifu_req", ifu_req, (j <= 5 || j == 9) ? 1 : 0);
      chk("jr_latch", inst_latch_en, (j == 5) ? 1 : 0);
      chk("jr_jump_sel", pc_jump_sel, (j == 8) ? 1 : 0);
      chk("jr_gpr_wr_en", gpr_wr_en, (j == 8) ? 1 : 0);
      if (ifu_req && j <= 8) req_hi++;
    end
    chk("jr_req_cycles", 64'(req_hi), 6);
    chk("jr_retire_cnt", retire_cnt, 5);
    $display("txn jalr: ifu_req held %0d cycles, retire_cnt=%0d", req_hi, retire_cnt);

    // Mid-operation reset drops the fetch in progress
    jalr_jump_en = 1'b0; ifu_rvalid = 1'b1;
    rst = 1'b1;
    step(); #1;
    chk("midrst_ifu_req", ifu_req, 0);
    chk("midrst_retire_cnt", retire_cnt, 0);
    step();

    // ebreak after two retired instructions (second is jal); rvalid keeps toggling after halt
    rst = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) step();
      jal_jump_en = (c >= 5 && c <= 8);
      ebreak      = (c >= 9);
      ifu_rvalid  = (c <= 9) ? 1'b1 : 1'(c % 2);
      #1;
      chk("eb_halted", halted, (c >= 11) ? 1 : 0);
      chk("eb_ifu_req", ifu_req, (c == 1 || c == 5 || c == 9) ? 1 : 0);
      chk("eb_retire", retire_pulse, (c == 4 || c == 8) ? 1 : 0);
      chk("eb_jump_sel", pc_jump_sel, (c == 8) ? 1 : 0);
      if (c >= 11) chk("eb_latch", inst_latch_en, 0);
    end
    chk("eb_retire_cnt", retire_cnt, 2);
    $display("txn ebreak: halted=%0d retire_cnt=%0d", halted, retire_cnt);

    // Memory timeout
    ebreak = 1'b0; jal_jump_en = 1'b0; ifu_rvalid = 1'b1; lsu_opt_code = 4'h1; lsu_done = 1'b0;
    do_reset();
`ifdef YSYX_23060191_EXEC_CTRL_TIMEOUT_EN
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) step();
      #1;
      chk("to_lsu_req", lsu_req, (c >= 4 && c <= 11) ? 1 : 0);
      chk("to_halted", halted, (c >= 12) ? 1 : 0);
      chk("to_err", timeout_err, (c >= 12) ? 1 : 0);
    end
    chk("to_retire_cnt", retire_cnt, 0);
    rst = 1'b1;
    step(); #1;
    chk("to_rst_halted", halted, 0);
    chk("to_rst_err", timeout_err, 0);
    step();
    // Response on the limit cycle wins over the timeout
    rst = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) step();
      lsu_done = (c == 11);
      #1;
      chk("tw_retire", retire_pulse, (c == 12) ? 1 : 0);
      chk("tw_err", timeout_err, 0);
      chk("tw_halted", halted, 0);
    end
    $display("txn timeout: limit-cycle response retired, timeout_err=%0d", timeout_err);
`else
    for (int c = 0; c <= 1003; c++) begin
      if (c > 0) step();
      #1;
      chk("nto_lsu_req", lsu_req, (c >= 4) ? 1 : 0);
      chk("nto_err", timeout_err, 0);
      chk("nto_halted", halted, 0);
    end
    $display("txn no-timeout: lsu_req=%0d after 1000 MEM cycles", lsu_req);
`endif
    lsu_opt_code = 4'd0; lsu_done = 1'b0;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
